// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - shared types for the hash table lookup pipeline
//
// Package hash_table
//   BUCKET_WIDTH    : head-table address width
//   HEAD_PTR_WIDTH  : width of a chain head pointer
//   ht_cmd_t        : task command
//   ht_pdata_t      : pipeline task {cmd, bucket, head_ptr, head_ptr_val}
//   head_ram_data_t : head-table word {ptr, ptr_val}
package hash_table;

    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 8;

    typedef enum logic [1:0] {
        CMD_LOOKUP = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_NOP    = 2'd3
    } ht_cmd_t;

    typedef struct packed {
        ht_cmd_t                   cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

endpackage

// File: rtl/head_rd_fifo.sv
// rtl/head_rd_fifo.sv - show-ahead synchronous FIFO of ht_pdata_t
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (clears pointers)
//   i_push       : write i_data (caller guarantees not full)
//   i_data       : entry to write
//   i_pop        : consume head entry (ignored when empty)
//   o_data       : head entry, valid while !o_empty
//   o_empty      : no entries
//   o_full       : DEPTH entries held (for checking only)
module head_rd_fifo
    import hash_table::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      i_push,
    input  ht_pdata_t i_data,
    input  logic      i_pop,
    output ht_pdata_t o_data,
    output logic      o_empty,
    output logic      o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    ht_pdata_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_data   = r_mem[r_rd_ptr];
    assign w_do_pop = i_pop && !o_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)   r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (i_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/head_table_rd_stage.sv
// rtl/head_table_rd_stage.sv - reads bucket head pointer and merges it into the task
//
// Optional feature macro: HEAD_TABLE_WR_FORWARD_EN (forward snooped head-table
// writes into in-flight reads).
//
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   task_i/_valid_i    : incoming hashed task; task_ready_o accepts
//   rd_addr_o, rd_en_o : head-table read request (issued in the accept cycle)
//   rd_data_i          : read data, valid RAM_LATENCY cycles after rd_en_o
//   head_wr_*_i        : head-table write snoop
//   task_o/_valid_o    : task with head fields filled; task_ready_i pops
//   busy_o             : tasks in flight or buffered
module head_table_rd_stage
    import hash_table::*;
#(
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  ht_pdata_t               task_i,
    input  logic                    task_valid_i,
    output logic                    task_ready_o,
    output logic [BUCKET_WIDTH-1:0] rd_addr_o,
    output logic                    rd_en_o,
    input  head_ram_data_t          rd_data_i,
    input  logic                    head_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] head_wr_addr_i,
    input  head_ram_data_t          head_wr_data_i,
    output ht_pdata_t               task_o,
    output logic                    task_valid_o,
    input  logic                    task_ready_i,
    output logic                    busy_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_fifo_push;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;
    ht_pdata_t               w_push_data;
    head_ram_data_t          w_merge_data;
    logic                    w_unused;

    logic [RAM_LATENCY-1:0]  r_dl_vld;
    ht_cmd_t                 r_dl_cmd    [RAM_LATENCY];
    logic [BUCKET_WIDTH-1:0] r_dl_bucket [RAM_LATENCY];

    // Credits cover every task between accept and pop, so the FIFO always
    // has room for whatever the RAM returns.
    assign task_ready_o = (r_cnt < CNT_W'(FIFO_DEPTH));
    assign w_accept     = task_valid_i && task_ready_o;
    assign rd_en_o      = w_accept;
    assign rd_addr_o    = w_accept ? task_i.bucket : '0;
    assign w_pop        = task_valid_o && task_ready_i;
    assign busy_o       = (r_cnt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dl_vld <= '0;
        end else begin
            r_dl_vld[0] <= w_accept;
            for (int k = 1; k < RAM_LATENCY; k++) r_dl_vld[k] <= r_dl_vld[k-1];
        end
    end

    // Payload is qualified by r_dl_vld, so it needs neither reset nor enable.
    always_ff @(posedge clk_i) begin
        r_dl_cmd[0]    <= task_i.cmd;
        r_dl_bucket[0] <= task_i.bucket;
        for (int k = 1; k < RAM_LATENCY; k++) begin
            r_dl_cmd[k]    <= r_dl_cmd[k-1];
            r_dl_bucket[k] <= r_dl_bucket[k-1];
        end
    end

`ifdef HEAD_TABLE_WR_FORWARD_EN
    logic [RAM_LATENCY-1:0] r_ovr_vld;
    head_ram_data_t         r_ovr_data [RAM_LATENCY];
    logic [RAM_LATENCY-1:0] w_wr_hit;

    // w_wr_hit[k]: the entry moving into stage k matches this cycle's write.
    always_comb begin
        w_wr_hit    = '0;
        w_wr_hit[0] = w_accept && head_wr_en_i && (head_wr_addr_i == task_i.bucket);
        for (int k = 1; k < RAM_LATENCY; k++) begin
            w_wr_hit[k] = r_dl_vld[k-1] && head_wr_en_i
                          && (head_wr_addr_i == r_dl_bucket[k-1]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovr_vld <= '0;
        end else begin
            r_ovr_vld[0] <= w_wr_hit[0];
            for (int k = 1; k < RAM_LATENCY; k++) begin
                r_ovr_vld[k] <= w_wr_hit[k] || r_ovr_vld[k-1];
            end
        end
    end

    // A newer matching write replaces an older override as the entry travels.
    always_ff @(posedge clk_i) begin
        r_ovr_data[0] <= head_wr_data_i;
        for (int k = 1; k < RAM_LATENCY; k++) begin
            r_ovr_data[k] <= w_wr_hit[k] ? head_wr_data_i : r_ovr_data[k-1];
        end
    end

    assign w_merge_data = r_ovr_vld[RAM_LATENCY-1] ? r_ovr_data[RAM_LATENCY-1] : rd_data_i;
    assign w_unused     = ^{w_fifo_full, task_i.head_ptr, task_i.head_ptr_val};
`else
    assign w_merge_data = rd_data_i;
    assign w_unused     = ^{w_fifo_full, task_i.head_ptr, task_i.head_ptr_val,
                            head_wr_en_i, head_wr_addr_i, head_wr_data_i};
`endif

    always_comb begin
        w_push_data              = '0;
        w_push_data.cmd          = r_dl_cmd[RAM_LATENCY-1];
        w_push_data.bucket       = r_dl_bucket[RAM_LATENCY-1];
        w_push_data.head_ptr     = w_merge_data.ptr;
        w_push_data.head_ptr_val = w_merge_data.ptr_val;
    end

    assign w_fifo_push = r_dl_vld[RAM_LATENCY-1];

    head_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_fifo_push),
        .i_data  (w_push_data),
        .i_pop   (task_ready_i),
        .o_data  (task_o),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign task_valid_o = !w_fifo_empty;

endmodule

// File: tb/tb_head_table_rd_stage.sv
// tb/tb_head_table_rd_stage.sv - self-checking bench for head_table_rd_stage
module tb_head_table_rd_stage;
    import hash_table::*;

    localparam int RAM_LATENCY = 2;
    localparam int FIFO_DEPTH  = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    ht_pdata_t               task_i;
    logic                    task_valid_i;
    logic                    task_ready_o;
    logic [BUCKET_WIDTH-1:0] rd_addr_o;
    logic                    rd_en_o;
    head_ram_data_t          rd_data_i;
    logic                    head_wr_en_i;
    logic [BUCKET_WIDTH-1:0] head_wr_addr_i;
    head_ram_data_t          head_wr_data_i;
    ht_pdata_t               task_o;
    logic                    task_valid_o;
    logic                    task_ready_i;
    logic                    busy_o;

    always #5 clk_i = ~clk_i;

    head_table_rd_stage #(
        .RAM_LATENCY (RAM_LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .task_i         (task_i),
        .task_valid_i   (task_valid_i),
        .task_ready_o   (task_ready_o),
        .rd_addr_o      (rd_addr_o),
        .rd_en_o        (rd_en_o),
        .rd_data_i      (rd_data_i),
        .head_wr_en_i   (head_wr_en_i),
        .head_wr_addr_i (head_wr_addr_i),
        .head_wr_data_i (head_wr_data_i),
        .task_o         (task_o),
        .task_valid_o   (task_valid_o),
        .task_ready_i   (task_ready_i),
        .busy_o         (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Head-table RAM: read sampled in the rd_en_o cycle, returned RAM_LATENCY
    // cycles later; junk on the bus whenever no read is due.
    head_ram_data_t ram [2**BUCKET_WIDTH];
    head_ram_data_t rd_pipe [RAM_LATENCY];

    always @(posedge clk_i) begin
        rd_pipe[0] <= rd_en_o ? ram[rd_addr_o]
                              : '{ptr: HEAD_PTR_WIDTH'($urandom), ptr_val: 1'($urandom)};
        for (int k = 1; k < RAM_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign rd_data_i = rd_pipe[RAM_LATENCY-1];

    // Reference: every accepted task comes out in accept order carrying the
    // head-table word for its bucket as it stood at accept time.
    ht_pdata_t exp_q [$];
    ht_pdata_t sb_exp;
    bit        sb_en = 1'b1;
    int        n_out = 0;

    function automatic ht_pdata_t model(input ht_pdata_t t);
        ht_pdata_t r;
        r              = t;
        r.head_ptr     = ram[t.bucket].ptr;
        r.head_ptr_val = ram[t.bucket].ptr_val;
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
        end else begin
            if (task_valid_o && task_ready_i) begin
                n_out++;
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_output", 1, 0);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        check("sb_output", task_o, sb_exp);
                    end
                end
            end
            if (task_valid_i && task_ready_o && sb_en) exp_q.push_back(model(task_i));
            if (dut.w_fifo_push) check("fifo_push_not_full", dut.w_fifo_full, 0);
        end
    end

    task automatic wait_out(input string name, output ht_pdata_t o, output int lat);
        lat = 0;
        while (!task_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({name, "_timeout"}, task_valid_o, 1);
        o = task_o;
    endtask

    typedef struct {
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [1:0]                cmd;
        logic [HEAD_PTR_WIDTH-1:0] ram_ptr;
        logic                      ram_val;
        logic [HEAD_PTR_WIDTH-1:0] exp_ptr;
        logic                      exp_val;
        int                        exp_lat;
    } vec_t;

    vec_t      vecs [5];
    ht_pdata_t got;
    int        lat;
    int        acc;
    int        guard;
    int        vcount;
    int        out0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd5,   2'd0, 8'h1A, 1'b1, 8'h1A, 1'b1, 3};
        vecs[1] = '{8'd0,   2'd1, 8'hFF, 1'b0, 8'hFF, 1'b0, 3};
        vecs[2] = '{8'd255, 2'd2, 8'h00, 1'b1, 8'h00, 1'b1, 3};
        vecs[3] = '{8'd128, 2'd3, 8'h55, 1'b1, 8'h55, 1'b1, 3};
        vecs[4] = '{8'd5,   2'd0, 8'h3C, 1'b0, 8'h3C, 1'b0, 3};

        task_i         = '0;
        task_valid_i   = 1'b0;
        task_ready_i   = 1'b1;
        head_wr_en_i   = 1'b0;
        head_wr_addr_i = '0;
        head_wr_data_i = '0;
        for (int i = 0; i < 2**BUCKET_WIDTH; i++)
            ram[i] = '{ptr: HEAD_PTR_WIDTH'($urandom), ptr_val: 1'($urandom)};

        // Reset state
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid_o", task_valid_o, 0);
        check("rst_rd_en",   rd_en_o, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_busy",    busy_o, 0);
        check("rst_ready_o", task_ready_o, 1);
        rst_i = 1'b0;

        // Single-task table
        for (int i = 0; i < 5; i++) begin
            ram[vecs[i].bucket] = '{ptr: vecs[i].ram_ptr, ptr_val: vecs[i].ram_val};
            @(posedge clk_i); #1;
            task_i = '{cmd: ht_cmd_t'(vecs[i].cmd), bucket: vecs[i].bucket,
                       head_ptr: 8'hEE, head_ptr_val: 1'b0};
            task_valid_i = 1'b1;
            #1;
            check("vec_rd_en",   rd_en_o, 1);
            check("vec_rd_addr", rd_addr_o, vecs[i].bucket);
            @(posedge clk_i); #1;
            task_valid_i = 1'b0;
            #1;
            check("vec_rd_en_idle",   rd_en_o, 0);
            check("vec_rd_addr_idle", rd_addr_o, 0);
            check("vec_busy",         busy_o, 1);
            wait_out("vec", got, lat);
            check("vec_latency", 1 + lat, vecs[i].exp_lat);
            check("vec_head_ptr", got.head_ptr, vecs[i].exp_ptr);
            check("vec_head_val", got.head_ptr_val, vecs[i].exp_val);
            check("vec_bucket",   got.bucket, vecs[i].bucket);
            check("vec_cmd",      got.cmd, vecs[i].cmd);
            @(posedge clk_i); #1;
            check("vec_busy_after", busy_o, 0);
        end

        // 16 back-to-back tasks
        for (int i = 0; i < 16; i++)
            ram[i] = '{ptr: HEAD_PTR_WIDTH'($urandom), ptr_val: 1'($urandom)};
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk_i); #1;
                    task_i = '{cmd: CMD_LOOKUP, bucket: BUCKET_WIDTH'(i),
                               head_ptr: 8'h00, head_ptr_val: 1'b1};
                    task_valid_i = 1'b1;
                    #1;
                    check("b2b_ready", task_ready_o, 1);
                end
                @(posedge clk_i); #1;
                task_valid_i = 1'b0;
            end
            begin : collect
                int t;
                t = 0;
                @(negedge clk_i);
                while (!task_valid_o && t < 30) begin
                    @(negedge clk_i);
                    t++;
                end
                for (int i = 0; i < 16; i++) begin
                    check("b2b_valid",  task_valid_o, 1);
                    check("b2b_bucket", task_o.bucket, i);
                    check("b2b_ptr",    task_o.head_ptr, ram[i].ptr);
                    check("b2b_val",    task_o.head_ptr_val, ram[i].ptr_val);
                    @(negedge clk_i);
                end
            end
        join
        repeat (4) @(posedge clk_i);

        // Backpressure: exactly FIFO_DEPTH accepts with task_ready_i low
        #1;
        task_ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i); #1;
            task_i = '{cmd: CMD_INSERT, bucket: BUCKET_WIDTH'(20 + acc),
                       head_ptr: 8'h00, head_ptr_val: 1'b0};
            task_valid_i = 1'b1;
            #2;
            if (task_ready_o) acc++;
        end
        check("bp_accepts", acc, FIFO_DEPTH);
        check("bp_ready_low", task_ready_o, 0);
        @(posedge clk_i); #1;
        task_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("bp_ready_still_low", task_ready_o, 0);
        @(posedge clk_i); #1;
        task_ready_i = 1'b1;
        #1;
        check("bp_first_valid",  task_valid_o, 1);
        check("bp_first_bucket", task_o.bucket, 20);
        check("bp_ready_at_pop", task_ready_o, 0);
        for (int j = 1; j < 4; j++) begin
            @(posedge clk_i); #2;
            check("bp_valid",       task_valid_o, 1);
            check("bp_bucket",      task_o.bucket, 20 + j);
            check("bp_ready_after", task_ready_o, 1);
        end
        @(posedge clk_i); #2;
        check("bp_drained", task_valid_o, 0);
        check("bp_idle",    busy_o, 0);

        // Random valid/ready, 1000 accepted tasks
        for (int i = 0; i < 2**BUCKET_WIDTH; i++)
            ram[i] = '{ptr: HEAD_PTR_WIDTH'($urandom), ptr_val: 1'($urandom)};
        out0  = n_out;
        acc   = 0;
        guard = 0;
        while (acc < 1000 && guard < 20000) begin
            @(posedge clk_i); #1;
            task_valid_i = 1'($urandom_range(0, 1));
            task_ready_i = 1'($urandom_range(0, 1));
            task_i = '{cmd: ht_cmd_t'($urandom_range(0, 3)), bucket: BUCKET_WIDTH'($urandom),
                       head_ptr: HEAD_PTR_WIDTH'($urandom), head_ptr_val: 1'($urandom)};
            #2;
            if (task_valid_i && task_ready_o) acc++;
            guard++;
        end
        @(posedge clk_i); #1;
        task_valid_i = 1'b0;
        task_ready_i = 1'b1;
        guard = 0;
        while ((busy_o || task_valid_o) && guard < 100) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check("rand_accepted", acc, 1000);
        check("rand_busy_end", busy_o, 0);
        check("rand_sb_empty", exp_q.size(), 0);
        check("rand_outputs",  n_out - out0, 1000);

        // Reset with three tasks in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            task_i = '{cmd: CMD_DELETE, bucket: BUCKET_WIDTH'(40 + k),
                       head_ptr: 8'h00, head_ptr_val: 1'b0};
            task_valid_i = 1'b1;
        end
        @(posedge clk_i); #1;
        task_valid_i = 1'b0;
        check("rst_mid_pre_valid", task_valid_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_mid_valid_o", task_valid_o, 0);
        check("rst_mid_busy",    busy_o, 0);
        check("rst_mid_ready",   task_ready_o, 1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_i); #1;
            if (task_valid_o) vcount++;
        end
        check("rst_mid_no_output", vcount, 0);
        check("rst_mid_busy_after",  busy_o, 0);
        check("rst_mid_ready_after", task_ready_o, 1);

        // Write snoop racing in-flight reads
        sb_en = 1'b0;
        ram[7] = '{ptr: 8'h10, ptr_val: 1'b1};
        @(posedge clk_i); #1;
        task_i = '{cmd: CMD_LOOKUP, bucket: 8'd7, head_ptr: 8'h00, head_ptr_val: 1'b0};
        task_valid_i = 1'b1;
        @(posedge clk_i); #1;
        task_valid_i   = 1'b0;
        head_wr_en_i   = 1'b1;
        head_wr_addr_i = 8'd7;
        head_wr_data_i = '{ptr: 8'h22, ptr_val: 1'b1};
        ram[7]         = '{ptr: 8'h22, ptr_val: 1'b1};
        @(posedge clk_i); #1;
        head_wr_en_i = 1'b0;
        wait_out("fwd_late", got, lat);
`ifdef HEAD_TABLE_WR_FORWARD_EN
        check("fwd_late_ptr", got.head_ptr, 8'h22);
`else
        check("fwd_late_ptr", got.head_ptr, 8'h10);
`endif
        repeat (3) @(posedge clk_i);

        // Write in the accept cycle; RAM read returns the pre-write word
        ram[9] = '{ptr: 8'h31, ptr_val: 1'b1};
        #1;
        task_i = '{cmd: CMD_INSERT, bucket: 8'd9, head_ptr: 8'h00, head_ptr_val: 1'b0};
        task_valid_i   = 1'b1;
        head_wr_en_i   = 1'b1;
        head_wr_addr_i = 8'd9;
        head_wr_data_i = '{ptr: 8'h44, ptr_val: 1'b0};
        @(posedge clk_i); #1;
        task_valid_i = 1'b0;
        head_wr_en_i = 1'b0;
        ram[9]       = '{ptr: 8'h44, ptr_val: 1'b0};
        wait_out("fwd_same", got, lat);
`ifdef HEAD_TABLE_WR_FORWARD_EN
        check("fwd_same_ptr", got.head_ptr, 8'h44);
        check("fwd_same_val", got.head_ptr_val, 0);
`else
        check("fwd_same_ptr", got.head_ptr, 8'h31);
        check("fwd_same_val", got.head_ptr_val, 1);
`endif
        repeat (3) @(posedge clk_i);

        // Write to a different bucket must not disturb the read
        #1;
        task_i = '{cmd: CMD_LOOKUP, bucket: 8'd7, head_ptr: 8'h00, head_ptr_val: 1'b0};
        task_valid_i = 1'b1;
        @(posedge clk_i); #1;
        task_valid_i   = 1'b0;
        head_wr_en_i   = 1'b1;
        head_wr_addr_i = 8'd8;
        head_wr_data_i = '{ptr: 8'h77, ptr_val: 1'b1};
        ram[8]         = '{ptr: 8'h77, ptr_val: 1'b1};
        @(posedge clk_i); #1;
        head_wr_en_i = 1'b0;
        wait_out("fwd_other", got, lat);
        check("fwd_other_ptr", got.head_ptr, 8'h22);
        repeat (3) @(posedge clk_i);
        sb_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/head_table_rd_stage.md
Name: head_table_rd_stage

Overview:
- Upstream neighbour of the data-table search stage.
- Takes hashed tasks (bucket already computed), reads the bucket's head pointer from head-table RAM, and merges it into the task.
- Emits ht_pdata_t with head_ptr/head_ptr_val filled, in order, to the search stage.
- Absorbs the fixed RAM read latency with a credit-controlled output FIFO, so downstream backpressure never drops a RAM response.

Parameters:
RAM_LATENCY, 2, head-table RAM read latency in cycles (>=1)
FIFO_DEPTH, 4, output FIFO entries; >= RAM_LATENCY+1 required for one task/cycle throughput (>=1 legal)
BUCKET_WIDTH, BUCKET_WIDTH (package), head-table address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
task_i  in  ht_pdata_t  incoming task; cmd and bucket valid, head fields don't-care
task_valid_i  in  1  task valid
task_ready_o  out  1  task accepted when valid && ready
rd_addr_o  out  BUCKET_WIDTH  head-table read address
rd_en_o  out  1  head-table read strobe
rd_data_i  in  head_ram_data_t  {ptr, ptr_val}; valid RAM_LATENCY cycles after rd_en_o
head_wr_en_i  in  1  head-table write snoop (used only with feature)
head_wr_addr_i  in  BUCKET_WIDTH  snooped write address
head_wr_data_i  in  head_ram_data_t  snooped write data
task_o  out  ht_pdata_t  task with head_ptr/head_ptr_val filled
task_valid_o  out  1  output valid
task_ready_i  in  1  downstream ready
busy_o  out  1  at least one task in flight or buffered

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. During reset, delay-line valids, FIFO pointers and credit counter are all cleared. Output values: task_valid_o=0, rd_en_o=0, rd_addr_o=0, busy_o=0, task_ready_o=1. task_o is don't-care while task_valid_o=0.
- Credit counter cnt, width $clog2(FIFO_DEPTH+1):
  - Counts tasks accepted but not yet popped from the FIFO.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
  - task_ready_o = (cnt < FIFO_DEPTH). This is registered-state only, with no combinational path from task_ready_i.
- Accept cycle: rd_en_o = task_valid_i && task_ready_o, combinationally. rd_addr_o = task_i.bucket when rd_en_o=1, else 0.
- Delay line:
  - RAM_LATENCY stages of {valid, pdata}. Stage 0 loads on accept.
  - At the last stage, head_ptr = rd_data_i.ptr and head_ptr_val = rd_data_i.ptr_val are merged and the entry is pushed into the FIFO that same cycle.
  - Accept-to-task_valid_o latency is RAM_LATENCY+1 cycles when the FIFO is empty.
- FIFO:
  - Show-ahead: task_valid_o = !empty, task_o = head entry.
  - Pop on task_valid_o && task_ready_i.
  - The credit counter guarantees a push never hits a full FIFO. The bench asserts this (no push while full).
- Ordering: strict FIFO order; output order equals accept order.
- Throughput: 1 task/cycle sustained while task_ready_i=1 and FIFO_DEPTH >= RAM_LATENCY+1.
- Backpressure: with task_ready_i held 0, exactly FIFO_DEPTH tasks are accepted, then task_ready_o=0 until a pop. task_ready_o rises the cycle after the first pop.
- busy_o = (cnt != 0).
- Reset mid-operation: all in-flight and buffered tasks are dropped. RAM responses arriving after reset are ignored because the stage valids are cleared.
- head_wr_* ports are ignored when the feature is disabled.

Optional Feature:
HEAD_TABLE_WR_FORWARD_EN
- Enabled:
  - Each cycle, every valid delay-line stage whose bucket == head_wr_addr_i while head_wr_en_i=1 latches head_wr_data_i as an override and sets an override flag.
  - At merge, the override data (latest write wins) replaces rd_data_i.
  - A write in the same cycle as the accept of the same bucket also sets the override at stage 0.
  - This gives coherency with writes that race in-flight reads.
- Disabled: the override logic is absent and rd_data_i is always used.

Decomposition:
- Package hash_table holds:
  - ht_pdata_t fields: cmd, bucket, head_ptr, head_ptr_val.
  - head_ram_data_t: ptr, ptr_val.
  - BUCKET_WIDTH and HEAD_PTR_WIDTH.
- Sub-module head_rd_fifo: parameterised show-ahead synchronous FIFO (DEPTH, data type ht_pdata_t), with push, pop, empty, full. full is for assertion use only.

Test Plan:
- Single task bucket=5, RAM holds {ptr=0x1A, val=1}, RAM_LATENCY=2, ready=1 -> rd_en_o pulse with addr 5; task_valid_o at accept+3 with head_ptr=0x1A, head_ptr_val=1.
- 16 back-to-back tasks, buckets 0..15, ready=1 -> task_ready_o stays 1, 16 outputs in order on consecutive cycles, each head_ptr=RAM[bucket].
- task_ready_i=0, continuous input -> exactly 4 accepts, then task_ready_o=0. Raise ready -> the 4 buffered tasks emerge in order, task_ready_o=1 the cycle after the first pop.
- Random valid/ready at 50% for 1000 tasks -> scoreboard order and data match, no FIFO overflow assertion fires, busy_o=0 at the end.
- rst_i asserted with 3 tasks in flight -> task_valid_o=0 immediately, no output after release, cnt=0, task_ready_o=1.
- With HEAD_TABLE_WR_FORWARD_EN: accept bucket 7 (RAM ptr 0x10), write bucket 7 := {0x22,1} one cycle later -> output head_ptr=0x22. Without the macro -> output head_ptr=0x10.
